// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the binary-to-BCD result converter.
package bcd_pkg;

    localparam int IN_W_DEF   = 14;
    localparam int DIGITS_DEF = 5;
    localparam int NIB_W      = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Single-nibble double-dabble adjust: values of 5 or more get +3 before the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [NIB_W-1:0] nib_o
);

    // Inputs never exceed 9, so the sum stays within the nibble.
    assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bcd_result_converter.sv
// Sequential binary-to-BCD converter (one bit per clock) feeding the display driver.
// Optional leading-zero blank mask enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bcd_result_converter
    import bcd_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [IN_W-1:0]           result_i,
    input  logic                      sign_i,
    input  logic                      zflag_i,
    output logic [NIB_W*DIGITS-1:0]   bcd_o,
    output logic                      sign_out_o,
    output logic                      zero_out_o,
    output logic [DIGITS-1:0]         blank_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int BCD_W = NIB_W * DIGITS;
    localparam int SR_W  = BCD_W + IN_W;
    localparam int CNT_W = $clog2(IN_W + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SR_W-1:0]    sr_q;
    logic               sign_cap_q;
    logic               zflag_cap_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               sign_out_q;
    logic               zero_out_q;
    logic               busy_q;
    logic               done_q;

    logic [BCD_W-1:0]   adj;
    logic [SR_W-1:0]    sr_pre;
    logic [SR_W-1:0]    sr_d;
    logic [BCD_W-1:0]   bcd_d;
    logic               last_iter;
    logic               load_out;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (sr_q[IN_W + NIB_W*g +: NIB_W]),
            .nib_o (adj[NIB_W*g +: NIB_W])
        );
    end

    // Adjust the BCD field, then shift the whole {BCD, binary} register left by one.
    assign sr_pre    = {adj, sr_q[IN_W-1:0]};
    assign sr_d      = sr_pre << 1;
    assign bcd_d     = sr_d[SR_W-1:IN_W];
    assign last_iter = (cnt_q == CNT_W'(IN_W - 1));
    assign load_out  = (state_q == CONVERT) && last_iter;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            sign_cap_q  <= 1'b0;
            zflag_cap_q <= 1'b0;
            bcd_q       <= '0;
            sign_out_q  <= 1'b0;
            zero_out_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        sr_q        <= {{BCD_W{1'b0}}, result_i};
                        sign_cap_q  <= sign_i;
                        zflag_cap_q <= zflag_i;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= CONVERT;
                    end
                end
                CONVERT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        bcd_q      <= bcd_d;
                        zero_out_q <= zflag_cap_q;
                        // A zero product never displays as negative.
                        sign_out_q <= sign_cap_q & ~zflag_cap_q;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_d;
    logic [DIGITS-1:0] blank_q;

    // Digit i is blank when it and every digit above it are zero; the ones digit always shows.
    always_comb begin
        blank_d = '0;
        for (int i = 1; i < DIGITS; i++) begin
            blank_d[i] = ((bcd_d >> (NIB_W*i)) == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            blank_q <= '0;
        end else if (load_out) begin
            blank_q <= blank_d;
        end
    end

    assign blank_o = blank_q;
`else
    assign blank_o = '0;
`endif

    assign bcd_o      = bcd_q;
    assign sign_out_o = sign_out_q;
    assign zero_out_o = zero_out_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_bcd_result_converter.sv
// Directed bench with a scoreboard: expected conversions are queued at accepted starts.
module tb_bcd_result_converter;

    localparam int IN_W   = 14;
    localparam int DIGITS = 5;

    logic              clk;
    logic              reset_i;
    logic              start_i;
    logic [IN_W-1:0]   result_i;
    logic              sign_i;
    logic              zflag_i;
    logic [19:0]       bcd_o;
    logic              sign_out_o;
    logic              zero_out_o;
    logic [DIGITS-1:0] blank_o;
    logic              busy_o;
    logic              done_o;

    bcd_result_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .result_i   (result_i),
        .sign_i     (sign_i),
        .zflag_i    (zflag_i),
        .bcd_o      (bcd_o),
        .sign_out_o (sign_out_o),
        .zero_out_o (zero_out_o),
        .blank_o    (blank_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] bcd;
        logic        sgn;
        logic        zero;
        logic [4:0]  blank;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          m_busy   = 0;
    int          m_left   = 0;
    logic [19:0] held_bcd = '0;
    logic        held_sgn = 1'b0;
    logic        held_zero = 1'b0;
    logic [4:0]  held_blank = '0;
    bit          last_acc;

    function automatic logic [19:0] to_bcd(int v);
        logic [19:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] exp_blank(int v);
        logic [4:0] b;
        int         p;
        b = '0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        p = 10;
        for (int i = 1; i < 5; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
`else
        p = v;
`endif
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock: update the reference model at the edge, then check outputs 1ns later.
    task automatic tick();
        bit   acc;
        exp_t e;
        acc = !m_busy && start_i && !reset_i;
        @(posedge clk);
        cyc++;
        if (reset_i) begin
            m_busy = 0;
            sb.delete();
            held_bcd = '0; held_sgn = 0; held_zero = 0; held_blank = '0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) m_busy = 0;
        end
        if (acc) begin
            e.bcd   = to_bcd(int'(result_i));
            e.sgn   = sign_i & ~zflag_i;
            e.zero  = zflag_i;
            e.blank = exp_blank(int'(result_i));
            e.due   = cyc + IN_W;
            sb.push_back(e);
            m_busy = 1;
            m_left = IN_W;
        end
        last_acc = acc;
        #1;
        chk("busy", 32'(busy_o), 32'(m_busy));
        chk("done", 32'(done_o), 32'(sb.size() > 0 && sb[0].due == cyc));
        if (done_o && sb.size() > 0) begin
            e = sb.pop_front();
            held_bcd = e.bcd; held_sgn = e.sgn; held_zero = e.zero; held_blank = e.blank;
        end
        chk("bcd", 32'(bcd_o), 32'(held_bcd));
        chk("sign_out", 32'(sign_out_o), 32'(held_sgn));
        chk("zero_out", 32'(zero_out_o), 32'(held_zero));
        chk("blank", 32'(blank_o), 32'(held_blank));
    endtask

    task automatic conv(input int res, input logic s, input logic z);
        result_i = IN_W'(res);
        sign_i   = s;
        zflag_i  = z;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        result_i = IN_W'($urandom);
        sign_i   = 1'($urandom);
        zflag_i  = 1'($urandom);
        repeat (IN_W + 2) tick();
    endtask

    initial begin
        int n_acc;
        int flip;
        reset_i  = 1'b1;
        start_i  = 1'b0;
        result_i = '0;
        sign_i   = 1'b0;
        zflag_i  = 1'b0;
        repeat (2) tick();
        reset_i = 1'b0;
        tick();

        // Basic, zero, and full-range values
        conv(30, 1'b0, 1'b0);
        conv(0, 1'b1, 1'b1);
        conv(16383, 1'b0, 1'b0);
        conv(16129, 1'b1, 1'b0);
        conv(9, 1'b1, 1'b0);

        // Second start while busy is dropped
        result_i = 14'd42; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        result_i = 14'd99; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (IN_W + 2) tick();

        // Reset mid-conversion aborts with no done
        result_i = 14'd500; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (6) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("abort_bcd", 32'(bcd_o), 32'h0);
        chk("abort_busy", 32'(busy_o), 32'h0);
        repeat (IN_W + 2) tick();
        conv(7, 1'b0, 1'b0);

        // start held high: each accepted request must surface once, in order
        n_acc = 0;
        flip  = 0;
        result_i = 14'd12;
        start_i  = 1'b1;
        for (int c = 0; c < 200 && n_acc < 5; c++) begin
            tick();
            if (last_acc) begin
                n_acc++;
                flip = ~flip;
                result_i = flip ? 14'd9999 : 14'd12;
            end
        end
        start_i = 1'b0;
        chk("held_accepts", 32'(n_acc), 32'd5);
        repeat (IN_W + 2) tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
